rptr_empty_lvl: RTL

Next-generation read-side pointer and flag block for the async FIFO, in the rclk domain.
- Keeps the dual n-bit (binary plus gray) read pointer and the registered empty flag.
- Adds gray-to-binary decode of the synchronised write pointer, a registered fill level, a programmable almost-empty flag, an underflow error and a synchronous read-side flush.
- Drives the memory read address and feeds rptr to the write-domain synchroniser.

---
 rtl/fifo_ptr_pkg.sv | 13 +
 rtl/gray2bin.sv | 17 +
 rtl/rptr_empty_lvl.sv | 91 +++++++++
 3 files changed

// File: rtl/fifo_ptr_pkg.sv
// Shared async-FIFO pointer types and helpers for the read and write pointer blocks.
// Holds the default pointer geometry and the binary-to-gray encoder.
package fifo_ptr_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

    typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return (bin >> 1) ^ bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary decoder, shared by the read and write pointer blocks.
// Each binary bit is the XOR of all gray bits at or above its position.
module gray2bin #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side pointer, empty/almost-empty flags, fill level and underflow error (rclk domain).
// Define RPTR_ERR_STICKY_EN to make rerr sticky until rerr_clr; otherwise it pulses per underflow.
module rptr_empty_lvl
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rinc,
    input  logic                  rflush,
    input  logic                  rerr_clr,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    input  logic [ADDR_WIDTH:0]   rae_thresh,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  rerr
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rwbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] rdiff;
    logic          pop;
    logic          underflow;

    gray2bin #(
        .W(PW)
    ) u_wptr_dec (
        .gray(rq2_wptr),
        .bin (rwbin)
    );

    // Flush overrides any pop and suppresses the underflow it would otherwise raise.
    always_comb begin
        pop       = rinc & ~rempty & ~rflush;
        underflow = rinc & rempty & ~rflush;
        rbinnext  = rflush ? rwbin : rbin + {{ADDR_WIDTH{1'b0}}, pop};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        rdiff     = rwbin - rbinnext;
    end

    assign raddr = rbin[ADDR_WIDTH-1:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rlevel  <= '0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            raempty <= (rdiff <= rae_thresh);
            rlevel  <= rdiff;
        end
    end

`ifdef RPTR_ERR_STICKY_EN
    // A new underflow wins over a clear arriving in the same cycle.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rerr <= 1'b0;
        end else if (underflow) begin
            rerr <= 1'b1;
        end else if (rerr_clr) begin
            rerr <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = rerr_clr;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rerr <= 1'b0;
        end else begin
            rerr <= underflow;
        end
    end
`endif

endmodule
